// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Converts a binary value to BCD with a sequential shift-add-3 engine and
//   time-multiplexes the decimal digits onto one shared 7-segment bus.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load        start conversion of bin (sampled only while idle)
//   bin         unsigned binary value
//   busy        conversion in progress
//   done        one-cycle pulse when a new value is committed to the display
//   overflow    last committed value >= 10**DIGITS
//   seg         segments a..g on bits 0..6, active-high
//   dig_en      one-hot digit enable, bit0 = least significant digit
//   dbg_state_o current converter FSM state (debug observation)
//
// Handshake: load is a request qualified by busy=0; while busy=1 any load
// is dropped. done marks the single cycle in which the new value becomes
// the display source.
module bcd_scan_display #(
  parameter int BINWIDTH = 8,
  parameter int DIGITS   = 3,
  parameter int SCANDIV  = 1000,
  parameter int LZBLANK  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BINWIDTH-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_en,
  output logic [1:0]          dbg_state_o
);

  localparam int          BCDW  = DIGITS * 4;
  localparam int          CW    = $clog2(BINWIDTH + 1);
  localparam int          PW    = $clog2(SCANDIV);
  localparam int          IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  logic [BINWIDTH-1:0] sh_q;
  logic [BCDW-1:0]     bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_lat_q;
  logic [BCDW-1:0]     disp_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic [6:0]          seg_q;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   dig_q;
  logic [DIGITS-1:0]   dig_d;
  logic [BCDW-1:0]     bcd_adj;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1100111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any nibble >= 5 becomes >= 8 after +3, so the
  // following shift carries it into the next decade.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            sh_q      <= bin;
            bcd_q     <= '0;
            cnt_q     <= CW'(BINWIDTH);
            ovf_lat_q <= (64'(bin) >= LIMIT);
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_q == '0) begin
            // All bits consumed: publish result and pulse done in COMMIT.
            disp_q  <= bcd_q;
            ovf_q   <= ovf_lat_q;
            done_q  <= 1'b1;
            state_q <= S_COMMIT;
          end else begin
            // Bits leaving the top of the accumulator are dropped; the
            // latched range compare reports that case.
            {bcd_q, sh_q} <= {bcd_adj[BCDW-2:0], sh_q, 1'b0};
            cnt_q         <= cnt_q - 1'b1;
          end
        end
        S_COMMIT: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Next scan slot. The very first wrap after reset shows digit 0 rather
  // than advancing, so the scan always starts at the least significant digit.
  always_comb begin
    int unsigned sel;
    logic [3:0]  nib;
    logic        blank;
    idx_d = idx_q;
    if (dig_q != '0) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    dig_d        = '0;
    dig_d[idx_d] = 1'b1;
    sel   = 32'(idx_d);
    nib   = disp_q[sel*4 +: 4];
    blank = (LZBLANK != 0) && (sel != 0) && ((disp_q >> (sel * 4)) == '0);
    if (ovf_q)      seg_d = 7'b1000000;
    else if (blank) seg_d = 7'b0000000;
    else            seg_d = seg_decode(nib);
  end

  // seg/dig_en only change on the prescaler wrap, so a display update
  // mid-slot never glitches the digit currently lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
    end else if (presc_q == PW'(SCANDIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign seg         = seg_q;
  assign dig_en      = dig_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S5 = 7'b1101101, S7 = 7'b0000111,
                         S8 = 7'b1111111, S9 = 7'b1100111, BL = 7'b0000000,
                         DASH = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] bin;

  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] dig_a, dig_b;
  logic [1:0] dig_c;
  logic [1:0] st_a, st_b, st_c;

  logic [6:0] seg_w[3];
  logic [2:0] dig_w[3];
  logic       done_w[3];
  logic       ovf_w[3];

  // Each entry: {overflow, seg digit2, seg digit1, seg digit0}
  logic [21:0] qa[$];
  logic [21:0] qb[$];
  logic [21:0] qc[$];

  int total = 0;
  int bad   = 0;
  int n_exp = 0;
  int done_cnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  bcd_scan_display #(.BINWIDTH(8), .DIGITS(3), .SCANDIV(4), .LZBLANK(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .bin(bin), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .seg(seg_a), .dig_en(dig_a), .dbg_state_o(st_a));
  bcd_scan_display #(.BINWIDTH(8), .DIGITS(3), .SCANDIV(4), .LZBLANK(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .bin(bin), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .seg(seg_b), .dig_en(dig_b), .dbg_state_o(st_b));
  bcd_scan_display #(.BINWIDTH(8), .DIGITS(2), .SCANDIV(4), .LZBLANK(1)) dut_c (
    .clk(clk), .rst(rst), .load(load), .bin(bin), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .seg(seg_c), .dig_en(dig_c), .dbg_state_o(st_c));

  assign seg_w[0] = seg_a;  assign seg_w[1] = seg_b;  assign seg_w[2] = seg_c;
  assign dig_w[0] = dig_a;  assign dig_w[1] = dig_b;  assign dig_w[2] = {1'b0, dig_c};
  assign done_w[0] = done_a; assign done_w[1] = done_b; assign done_w[2] = done_c;
  assign ovf_w[0] = ovf_a;  assign ovf_w[1] = ovf_b;  assign ovf_w[2] = ovf_c;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [21:0] pk(input logic o, input logic [6:0] d2, input logic [6:0] d1,
                                     input logic [6:0] d0);
    return {o, d2, d1, d0};
  endfunction

  function automatic logic pop_exp(input int u, output logic [21:0] e);
    e = '0;
    case (u)
      0: if (qa.size() > 0) begin e = qa.pop_front(); return 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); return 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Monitor: on each done, pop the expectation, then collect one full scan
  // round of the new display and compare every digit.
  task automatic mon_once(input int u);
    logic [21:0] e;
    logic [6:0]  got[3];
    logic [2:0]  prev;
    int          nd;
    int          waited;
    int          idx;
    @(negedge clk);
    if (rst || !done_w[u]) return;
    done_cnt[u]++;
    nd = (u == 2) ? 2 : 3;
    if (!pop_exp(u, e)) begin
      chk($sformatf("u%0d_unexpected_done", u), 1, 0);
      return;
    end
    chk($sformatf("u%0d_overflow", u), 32'(ovf_w[u]), 32'(e[21]));
    got  = '{BL, BL, BL};
    prev = dig_w[u];
    for (int k = 0; k < nd; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (dig_w[u] == prev && waited < 20);
      if (dig_w[u] == prev) begin
        chk($sformatf("u%0d_scan_timeout", u), 1, 0);
        return;
      end
      prev = dig_w[u];
      chk($sformatf("u%0d_onehot", u), 32'($countones(prev)), 1);
      idx = 0;
      for (int j = 0; j < 3; j++) if (prev[j]) idx = j;
      got[idx] = seg_w[u];
    end
    for (int k = 0; k < nd; k++)
      chk($sformatf("u%0d_digit%0d", u, k), 32'(got[k]), 32'(e[k*7 +: 7]));
  endtask

  initial forever mon_once(0);
  initial forever mon_once(1);
  initial forever mon_once(2);

  // Driver: issue one load, push expectations, check latency on dut_a.
  // glitch=1 adds two extra load pulses (bin=42) while busy.
  task automatic do_load(input logic [7:0] v, input logic [21:0] ea, input logic [21:0] eb,
                         input logic [21:0] ec, input logic glitch);
    int busy_n;
    int done_at;
    qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
    n_exp++;
    @(negedge clk);
    bin  = v;
    load = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    busy_n  = 0;
    done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (glitch && (k == 3 || k == 5)) begin
        load = 1'b1;
        bin  = 8'd42;
      end else begin
        load = 1'b0;
      end
      if (k <= 9 && busy_a) busy_n++;
      if (k == 10) chk("busy_drop", 32'(busy_a), 0);
      if (done_a) done_at = (done_at == -1) ? k : 100;
    end
    chk("busy_window", 32'(busy_n), 9);
    chk("done_cycle", 32'(done_at), 9);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    bin  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_seg", 32'(seg_a), 0);
    chk("rst_dig", 32'(dig_a), 0);
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      case (c)
        3: begin
          chk("scan_a_c3", 32'(dig_a), 32'b000);
          chk("scan_c_c3", 32'(dig_c), 32'b00);
        end
        4: begin
          chk("scan_a_dig_c4", 32'(dig_a), 32'b001); chk("scan_a_seg_c4", 32'(seg_a), 32'(S0));
          chk("scan_b_seg_c4", 32'(seg_b), 32'(S0)); chk("scan_c_dig_c4", 32'(dig_c), 32'b01);
        end
        8: begin
          chk("scan_a_dig_c8", 32'(dig_a), 32'b010); chk("scan_a_seg_c8", 32'(seg_a), 32'(BL));
          chk("scan_b_seg_c8", 32'(seg_b), 32'(S0)); chk("scan_c_dig_c8", 32'(dig_c), 32'b10);
        end
        12: begin
          chk("scan_a_dig_c12", 32'(dig_a), 32'b100); chk("scan_a_seg_c12", 32'(seg_a), 32'(BL));
          chk("scan_b_seg_c12", 32'(seg_b), 32'(S0)); chk("scan_c_dig_c12", 32'(dig_c), 32'b01);
        end
        16: chk("scan_a_dig_c16", 32'(dig_a), 32'b001);
        default: ;
      endcase
    end

    do_load(8'd255, pk(0, S2, S5, S5), pk(0, S2, S5, S5), pk(1, BL, DASH, DASH), 1'b0);
    do_load(8'd7,   pk(0, BL, BL, S7), pk(0, S0, S0, S7), pk(0, BL, BL, S7),     1'b0);
    do_load(8'd0,   pk(0, BL, BL, S0), pk(0, S0, S0, S0), pk(0, BL, BL, S0),     1'b0);
    do_load(8'd208, pk(0, S2, S0, S8), pk(0, S2, S0, S8), pk(1, BL, DASH, DASH), 1'b0);
    do_load(8'd99,  pk(0, BL, S9, S9), pk(0, S0, S9, S9), pk(0, BL, S9, S9),     1'b0);
    do_load(8'd10,  pk(0, BL, S1, S0), pk(0, S0, S1, S0), pk(0, BL, S1, S0),     1'b1);
    do_load(8'd100, pk(0, S1, S0, S0), pk(0, S1, S0, S0), pk(1, BL, DASH, DASH), 1'b0);

    // Abort a conversion with reset during its 4th SHIFT cycle.
    @(negedge clk);
    bin  = 8'd200;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_seg", 32'(seg_a), 0);
    chk("abort_dig", 32'(dig_a), 0);
    chk("abort_ovf_c", 32'(ovf_c), 0);
    chk("abort_state", 32'(st_a), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt[0]), 32'(n_exp - 0));

    do_load(8'd3, pk(0, BL, BL, S3), pk(0, S0, S0, S3), pk(0, BL, BL, S3), 1'b0);

    for (int u = 0; u < 3; u++) chk($sformatf("u%0d_done_count", u), 32'(done_cnt[u]), 32'(n_exp));
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    chk("qc_empty", 32'(qc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
